// File: rtl/movefrom_sequencer.sv
// T-state sequencer for instruction fetch plus mfhi/mflo execute, with memory wait states.
// Fetch+execute takes 3+MEM_WAIT cycles; illegal opcodes park in FAULT until clr.
module movefrom_sequencer #(
    parameter int              DATA_W   = 32,
    parameter int              OP_W     = 5,
    parameter logic [OP_W-1:0] MFHI_OP  = 5'b11000,
    parameter logic [OP_W-1:0] MFLO_OP  = 5'b11001,
    parameter int              MEM_WAIT = 1,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic [DATA_W-1:0] ir_in,
    output logic              PCout,
    output logic              MARin,
    output logic              IncPC,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Gra,
    output logic              Rin,
    output logic              HIout,
    output logic              LOout,
    output logic              busy,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_T0    = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    // MEM_WAIT is legal in 1..15, so four bits always hold the reload value.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t          state, state_nxt;
    logic [3:0]      wait_cnt;
    logic [OP_W-1:0] opcode;
    logic            is_mfhi, is_mflo, op_legal;
    logic            ir_unused;

    assign opcode    = ir_in[DATA_W-1 -: OP_W];
    assign ir_unused = ^ir_in[DATA_W-OP_W-1:0];
    assign is_mfhi   = (opcode == MFHI_OP);
    assign is_mflo   = (opcode == MFLO_OP);
    assign op_legal  = is_mfhi | is_mflo;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            retired  <= '0;
        end else begin
            state <= state_nxt;
            // Counter is armed on the T0->T1 edge so T1 lasts exactly MEM_WAIT cycles.
            if (state == S_T0)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_T1 && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == S_T3 && op_legal)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Rin        = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        busy       = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_IDLE: begin
                if (run)
                    state_nxt = S_T0;
            end
            S_T0: begin
                busy      = 1'b1;
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                busy  = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                if (wait_cnt == 4'd0)
                    state_nxt = S_T2;
            end
            S_T2: begin
                busy      = 1'b1;
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                busy = 1'b1;
                if (op_legal) begin
                    Gra       = 1'b1;
                    Rin       = 1'b1;
                    HIout     = is_mfhi;
                    LOout     = is_mflo;
                    state_nxt = run ? S_T0 : S_IDLE;
                end else begin
                    state_nxt = S_FAULT;
                end
            end
            S_FAULT: begin
                illegal_op = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
